mem_reg: RTL and testbench
==========================

Name: mem_reg

Overview:
- Selection-memory register for the 5-to-3 commutator.
- Samples the asynchronous 3-bit control code, synchronizes it to clk, and holds the last valid channel selection on out.
- Invalid codes (selector values >= NUM_INPUTS) are ignored, so the commutator never sees an out-of-range selection.
- Sits between the free-running control source and the commutator multiplexer.

Parameters:
- WIDTH, 3, width of control and out.
- NUM_INPUTS, 5, number of commutator inputs; valid codes are 0..NUM_INPUTS-1.
- SYNC_STAGES, 2, number of synchronizer flops on control; legal range 2..4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- control  input  WIDTH  requested selection code; asynchronous to clk and may change at any time, including near clock edges.
- out  output  WIDTH  registered, validated selection code.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all synchronizer stages and out are 0, immediately and independent of clk.
  - Release is taken at the next rising clk edge.
- Synchronizer: chain sync[0..SYNC_STAGES-1] of WIDTH-bit flops.
  - sync[0] <= control; sync[i] <= sync[i-1].
  - Each bit is synchronized independently; a bit changing in the setup/hold window may resolve to either value.
- Output update on each rising clk edge:
  - If sync[SYNC_STAGES-1] < NUM_INPUTS, out <= sync[SYNC_STAGES-1].
  - Otherwise out holds its previous value.
- Latency: control stable before rising edge k appears on out after edge k+SYNC_STAGES. With the default, out reflects it after edge k+2 (3 register stages total).
- Control pulses shorter than one clk period may be missed entirely; this is legal and required (no pulse stretching).
- Comparison is unsigned over WIDTH bits. If NUM_INPUTS >= 2^WIDTH, every code is valid.
- out changes only on rising clk edges or asynchronous reset assertion; it is glitch-free (direct flop output).
- Reset asserted mid-operation: out goes to 0 at once and the pipeline is flushed.
  - After release, out stays 0 until a valid nonzero code propagates through the synchronizer.
- Invalid code held indefinitely: out retains the last valid code indefinitely.
- Invalid followed by valid: out updates to the valid code with normal latency; no extra delay penalty.
- Simultaneous multi-bit control change near an edge: an intermediate code may be captured.
  - It is accepted if valid and dropped if invalid.
  - It is corrected on a following edge once control is stable.
- No X propagation after reset: every flop has a defined reset value.

Test Plan:
- Reset: rst_n=0 for 2 cycles with control=3'b011 -> out=0 throughout. Assert rst_n=0 asynchronously between edges mid-run -> out=0 before the next edge.
- Latency: after reset, control=3'b010 set before edge k -> out=0 after edges k and k+1, out=3'b010 after edge k+2.
- Invalid hold: control=3'b100 until out=3'b100, then control=3'b110 for 10 cycles -> out remains 3'b100. Then control=3'b001 -> out=3'b001 two edges later.
- Full sweep: drive codes 0..7 each for 4 cycles -> out follows 0,1,2,3,4, then stays 4 during 5,6,7.
- Asynchronous toggling: clk period 100 ns, control bits toggling every 30/27/25 ns for 400 ns (bit0/bit1/bit2).
  - out is always in 0..4 and changes only on rising clk edges.
  - Every out value equals a valid control sample taken SYNC_STAGES edges earlier.
- Short pulse: control=3'b001 for 20 ns between edges, otherwise 0 -> out stays 0 and no X appears.

Source files
------------

// File: rtl/mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_reg
// Purpose  : Selection-memory register for the 5-to-3 commutator. Brings the
//            free-running control code into the clk domain through a
//            multi-flop synchronizer. It holds the last in-range channel
//            selection on out, so the commutator never sees an invalid
//            selection.
// Ports    : clk     - system clock, rising-edge active
//            rst_n   - asynchronous active-low reset
//            control - requested selection code (asynchronous to clk)
//            out     - registered, validated selection code
// Revision : 1.0 - initial release
// ============================================================================
module mem_reg #(
  parameter int WIDTH       = 3,
  parameter int NUM_INPUTS  = 5,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] control,
  output logic [WIDTH-1:0] out
);

  // Synchronizer chain. Each bit resolves independently, so a multi-bit change
  // near an edge may produce an intermediate code. That code is filtered by
  // the validity check below and corrected on a later edge.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0]                  sync_last;
  logic                              code_valid;

  assign sync_last = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= control;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // When the code space is no larger than the number of inputs, every code is
  // valid. Skipping the compare in that case avoids truncating NUM_INPUTS.
  generate
    if (NUM_INPUTS >= (1 << WIDTH)) begin : g_all_valid
      assign code_valid = 1'b1;
    end else begin : g_range_check
      localparam logic [WIDTH-1:0] LIMIT = WIDTH'(NUM_INPUTS);
      assign code_valid = (sync_last < LIMIT);
    end
  endgenerate

  // Output drives straight from a flop, so it is glitch-free. Invalid codes
  // leave the previous selection in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (code_valid) begin
      out <= sync_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_reg.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_mem_reg
// Purpose  : Self-checking bench for mem_reg. A reference model treats the
//            synchronizer as a plain delay line of edge samples. Each edge,
//            the oldest sample becomes the selection if it is in range.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_reg;

  localparam int WIDTH       = 3;
  localparam int NUM_INPUTS  = 5;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] control = 3'b011;
  logic [WIDTH-1:0] out;

  int checks = 0;
  int failures = 0;

  mem_reg #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .control(control),
    .out    (out)
  );

  always #50 clk = ~clk;

  // Reference model: samples of control taken at each rising edge. A sample
  // emerges SYNC_STAGES edges later and is accepted only if in range.
  logic [WIDTH-1:0] dq[$] = '{3'd0, 3'd0};
  logic [WIDTH-1:0] exp_out = '0;
  time              last_edge = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [WIDTH-1:0] s;
    if (!rst_n) begin
      dq = {};
      for (int i = 0; i < SYNC_STAGES; i++) dq.push_back('0);
      exp_out = '0;
    end else begin
      s = dq.pop_front();
      if (int'(s) < NUM_INPUTS) exp_out = s;
      dq.push_back(control);
    end
  end

  always @(posedge clk) last_edge = $time;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // out may only move at a rising edge or while reset is asserted.
  always @(out) begin
    if (rst_n === 1'b1 && $time > 0) begin
      checks++;
      assert ($time == last_edge) else begin
        failures++;
        $error("FAIL out_edge_only observed_change_at=%0t expected_at=%0t",
               $time, last_edge);
      end
    end
  end

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, out, exp_out);
    end
  endtask

  initial begin
    // Reset held for two edges with a nonzero control value.
    #1;
    check("reset_t0", out, 3'b000);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_hold", out, 3'b000);
    end

    // Release between edges together with a new code: latency of 3 edges.
    rst_n   = 1'b1;
    control = 3'b010;
    step();  check("lat_k",   out, 3'b000);
    step();  check("lat_k1",  out, 3'b000);
    step();  check("lat_k2",  out, 3'b010);

    // Invalid code held: out keeps the last valid selection.
    control = 3'b100;
    run_model("to4", 3);
    check("reach4", out, 3'b100);
    control = 3'b110;
    for (int i = 0; i < 10; i++) begin
      step();
      check("inv_hold", out, 3'b100);
    end
    control = 3'b001;
    step();  check("rec_k",  out, 3'b100);
    step();  check("rec_k1", out, 3'b100);
    step();  check("rec_k2", out, 3'b001);

    // Full code sweep, 4 cycles per code.
    for (int c = 0; c < 8; c++) begin
      control = 3'(c);
      run_model("sweep_model", 4);
      check("sweep_end", out, (c < NUM_INPUTS) ? 3'(c) : 3'd4);
    end

    // Asynchronous per-bit toggling. The half-ns offset keeps every toggle
    // off the integer-ns clock edges, so edge samples are unambiguous.
    control = 3'b000;
    run_model("pre_toggle", 3);
    @(posedge clk);
    #3.5;
    fork
      for (int i = 0; i < 13; i++) begin #30; control[0] = ~control[0]; end
      for (int i = 0; i < 14; i++) begin #27; control[1] = ~control[1]; end
      for (int i = 0; i < 16; i++) begin #25; control[2] = ~control[2]; end
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        check("tog_edge", out, exp_out);
        check("tog_range", 3'(int'(out) < NUM_INPUTS), 3'd1);
        #47;
        check("tog_mid", out, exp_out);
      end
    join
    run_model("post_toggle", 4);

    // Short pulse between edges is never sampled.
    control = 3'b000;
    run_model("pulse_pre", 3);
    check("pulse_base", out, 3'b000);
    #39;
    control = 3'b001;
    #20;
    control = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("pulse_out", out, 3'b000);
    end

    // Randomised traffic, with an occasional second change mid-cycle.
    for (int i = 0; i < 200; i++) begin
      control = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        #(20 + $urandom_range(0, 50));
        control = 3'($urandom_range(0, 7));
      end
      step();
      check("rand", out, exp_out);
    end

    // Mid-run reset: out clears before the next edge and the pipe is flushed.
    control = 3'b011;
    run_model("pre_rst", 3);
    check("pre_rst_val", out, 3'b011);
    #20;
    rst_n = 1'b0;
    #1;
    check("async_rst", out, 3'b000);
    step();
    check("rst_hold", out, 3'b000);
    rst_n = 1'b1;
    step();  check("flush_k",  out, 3'b000);
    step();  check("flush_k1", out, 3'b000);
    step();  check("flush_k2", out, 3'b011);
    run_model("tail", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
